// File: rtl/apa102_in_if.sv
// Write bus from the APA102 receiver into sram_bus.
// Handshake: write_strobe is a one-cycle valid with no ready; the sink accepts a
// word every cycle. write_address/write_data are valid in the strobe cycle and
// hold until the next strobe.
interface apa102_in_if #(
  parameter int AW = 16
);
  logic [AW-1:0] write_address;
  logic [15:0]   write_data;
  logic          write_strobe;

  modport master (output write_address, output write_data, output write_strobe);
  modport slave  (input  write_address, input  write_data, input  write_strobe);
endinterface

// File: rtl/apa102_in.sv
// APA102 stream receiver: oversamples clock_in/data_in on the fabric clock,
// detects the 32-zero start frame, validates LED frame headers and writes each
// LED frame as two 16-bit words onto the sram_bus write interface.
// Optional idle timeout is built when APA102_IN_TIMEOUT_EN is defined.
module apa102_in #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES    = 4800,
  parameter int SYNC_STAGES       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDRESS_BUS_WIDTH-1:0] start_address,
  input  logic [ADDRESS_BUS_WIDTH-1:0] max_words,
  input  logic                         clock_in,
  input  logic                         data_in,
  apa102_in_if.master                  wr,
  output logic                         frame_done_strobe,
  output logic [ADDRESS_BUS_WIDTH-1:0] words_written,
  output logic                         header_error,
  output logic                         overflow,
  output logic [1:0]                   dbg_state
);

  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam logic [AW-1:0] AW_ONE = AW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Parameter range guard: fewer than two sync stages or a zero timeout is
  // not a supported configuration.
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_range
  end

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [5:0]             zero_cnt_q, zero_cnt_d;
  logic [31:0]            shift_q, shift_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic                   pend_lo_q, pend_lo_d;
  logic [15:0]            lo_word_q, lo_word_d;
  logic [AW-1:0]          base_q, base_d;
  logic [AW-1:0]          max_q, max_d;
  logic [AW-1:0]          words_written_q, words_written_d;
  logic [AW-1:0]          write_address_q, write_address_d;
  logic [15:0]            write_data_q, write_data_d;
  logic                   write_strobe_q, write_strobe_d;
  logic                   frame_done_q, frame_done_d;
  logic                   header_error_q, header_error_d;
  logic                   overflow_q, overflow_d;

  logic                   clk_s, bit_rise, bit_val, start_det;
  logic [31:0]            frame_word;
  logic                   emit_req;
  logic [15:0]            emit_word;

`ifdef APA102_IN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_VAL = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
  logic          any_edge, timeout_hit;
`endif

  assign clk_s      = clk_sync_q[SYNC_STAGES-1];
  assign bit_val    = data_sync_q[SYNC_STAGES-1];
  assign bit_rise   = clk_s & ~clk_prev_q;
  // The bit that takes the zero run from 31 to 32 is the start-frame detect.
  assign start_det  = bit_rise & ~bit_val & (zero_cnt_q == 6'd31);
  assign frame_word = {shift_q[30:0], bit_val};

`ifdef APA102_IN_TIMEOUT_EN
  assign any_edge    = clk_s ^ clk_prev_q;
  assign timeout_hit = !any_edge && (idle_cnt_q == TIMEOUT_VAL) &&
                       (state_q == ST_HUNT || state_q == ST_SHIFT);
`endif

  // Next-state logic: sync chain, zero run, frame FSM and write emission.
  always_comb begin
    clk_sync_d      = {clk_sync_q[SYNC_STAGES-2:0], clock_in};
    data_sync_d     = {data_sync_q[SYNC_STAGES-2:0], data_in};
    clk_prev_d      = clk_s;
    state_d         = state_q;
    zero_cnt_d      = zero_cnt_q;
    shift_d         = shift_q;
    bit_cnt_d       = bit_cnt_q;
    pend_lo_d       = 1'b0;
    lo_word_d       = lo_word_q;
    base_d          = base_q;
    max_d           = max_q;
    words_written_d = words_written_q;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    write_strobe_d  = 1'b0;
    frame_done_d    = 1'b0;
    header_error_d  = header_error_q;
    overflow_d      = overflow_q;
    emit_req        = 1'b0;
    emit_word       = 16'h0000;
`ifdef APA102_IN_TIMEOUT_EN
    if (any_edge)                   idle_cnt_d = '0;
    else if (idle_cnt_q == TIMEOUT_VAL) idle_cnt_d = idle_cnt_q;
    else                            idle_cnt_d = idle_cnt_q + TW'(1);
`endif

    if (bit_rise) begin
      if (bit_val)                   zero_cnt_d = 6'd0;
      else if (zero_cnt_q != 6'd32)  zero_cnt_d = zero_cnt_q + 6'd1;
    end

    if (start_det) begin
      // Start frame wins over everything, including a pending low word.
      frame_done_d    = (words_written_q != '0);
      base_d          = start_address;
      max_d           = max_words;
      words_written_d = '0;
      header_error_d  = 1'b0;
      overflow_d      = 1'b0;
      shift_d         = '0;
      bit_cnt_d       = '0;
      state_d         = ST_HUNT;
    end else begin
      if (pend_lo_q) begin
        emit_req  = 1'b1;
        emit_word = lo_word_q;
      end
      if (bit_rise) begin
        case (state_q)
          ST_HUNT: begin
            if (bit_val) begin
              shift_d   = 32'd1;
              bit_cnt_d = 5'd1;
              state_d   = ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (bit_cnt_q == 5'd31) begin
              bit_cnt_d = '0;
              shift_d   = '0;
              if (frame_word[31:29] == 3'b111) begin
                emit_req  = 1'b1;
                emit_word = frame_word[31:16];
                pend_lo_d = 1'b1;
                lo_word_d = frame_word[15:0];
              end else begin
                header_error_d = 1'b1;
              end
            end else begin
              shift_d   = frame_word;
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
          default: ;
        endcase
      end
`ifdef APA102_IN_TIMEOUT_EN
      if (timeout_hit) begin
        frame_done_d = (words_written_q != '0);
        shift_d      = '0;
        bit_cnt_d    = '0;
        pend_lo_d    = 1'b0;
        state_d      = ST_IDLE;
      end
`endif
      if (emit_req) begin
        if (words_written_q == max_q) begin
          overflow_d = 1'b1;
        end else begin
          write_strobe_d  = 1'b1;
          write_address_d = base_q + words_written_q;
          write_data_d    = emit_word;
          words_written_d = words_written_q + AW_ONE;
        end
      end
    end
  end

  // State and output registers, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      clk_sync_q      <= '0;
      data_sync_q     <= '0;
      clk_prev_q      <= 1'b0;
      zero_cnt_q      <= '0;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      pend_lo_q       <= 1'b0;
      lo_word_q       <= '0;
      base_q          <= '0;
      max_q           <= '0;
      words_written_q <= '0;
      write_address_q <= '0;
      write_data_q    <= '0;
      write_strobe_q  <= 1'b0;
      frame_done_q    <= 1'b0;
      header_error_q  <= 1'b0;
      overflow_q      <= 1'b0;
`ifdef APA102_IN_TIMEOUT_EN
      idle_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      clk_sync_q      <= clk_sync_d;
      data_sync_q     <= data_sync_d;
      clk_prev_q      <= clk_prev_d;
      zero_cnt_q      <= zero_cnt_d;
      shift_q         <= shift_d;
      bit_cnt_q       <= bit_cnt_d;
      pend_lo_q       <= pend_lo_d;
      lo_word_q       <= lo_word_d;
      base_q          <= base_d;
      max_q           <= max_d;
      words_written_q <= words_written_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      write_strobe_q  <= write_strobe_d;
      frame_done_q    <= frame_done_d;
      header_error_q  <= header_error_d;
      overflow_q      <= overflow_d;
`ifdef APA102_IN_TIMEOUT_EN
      idle_cnt_q      <= idle_cnt_d;
`endif
    end
  end

  assign wr.write_address   = write_address_q;
  assign wr.write_data      = write_data_q;
  assign wr.write_strobe    = write_strobe_q;
  assign frame_done_strobe  = frame_done_q;
  assign words_written      = words_written_q;
  assign header_error       = header_error_q;
  assign overflow           = overflow_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_apa102_in.sv
// Bench for apa102_in: directed and random APA102 bit streams, checked against
// a bit-level reference model built from the stream rules (zero run, hunt for
// the first 1, 32-bit frames, header check, word limit).
module tb_apa102_in;
  localparam int AW = 16;
  localparam int TIMEOUT_CYCLES = 4800;

  // Clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] start_address = '0;
  logic [AW-1:0] max_words = '0;
  logic          clock_in = 1'b0;
  logic          data_in = 1'b0;
  logic          frame_done_strobe;
  logic [AW-1:0] words_written;
  logic          header_error;
  logic          overflow;
  logic [1:0]    dbg_state;

  apa102_in_if #(.AW(AW)) bus ();

  apa102_in #(
    .ADDRESS_BUS_WIDTH(AW),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_address(start_address),
    .max_words(max_words),
    .clock_in(clock_in),
    .data_in(data_in),
    .wr(bus.master),
    .frame_done_strobe(frame_done_strobe),
    .words_written(words_written),
    .header_error(header_error),
    .overflow(overflow),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [AW+15:0] exp_q[$];
  int            m_zrun;
  bit            m_armed;
  bit            m_hunt;
  logic [31:0]   m_bits;
  int            m_nbits;
  logic [AW-1:0] m_base, m_max, m_ww;
  bit            m_herr, m_ovf;
  int            m_done;

  task automatic model_reset();
    m_zrun = 0; m_armed = 0; m_hunt = 0; m_bits = '0; m_nbits = 0;
    m_base = '0; m_max = '0; m_ww = '0; m_herr = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_word(input logic [15:0] d);
    if (m_ww == m_max) m_ovf = 1;
    else begin
      exp_q.push_back({m_base + m_ww, d});
      m_ww = m_ww + 1'b1;
    end
  endtask

  task automatic model_bit(input bit b);
    int prev;
    prev = m_zrun;
    if (b) m_zrun = 0;
    else if (m_zrun < 32) m_zrun++;
    if (!b && prev == 31) begin
      if (m_ww != 0) m_done++;
      m_base = start_address; m_max = max_words; m_ww = '0;
      m_herr = 0; m_ovf = 0; m_armed = 1; m_hunt = 1; m_nbits = 0;
    end else if (m_armed) begin
      if (m_hunt) begin
        if (b) begin m_hunt = 0; m_bits = 32'd1; m_nbits = 1; end
      end else begin
        m_bits = {m_bits[30:0], b};
        m_nbits++;
        if (m_nbits == 32) begin
          m_nbits = 0;
          if (m_bits[31:29] == 3'b111) begin
            model_word(m_bits[31:16]);
            model_word(m_bits[15:0]);
          end else m_herr = 1;
        end
      end
    end
  endtask

  // Scoreboard monitor
  int act_done = 0;
  longint cyc = 0;
  longint strobe_cyc[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (bus.write_strobe === 1'b1) begin
      logic [AW+15:0] e;
      strobe_cyc.push_back(cyc);
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", bus.write_address, e[AW+15:16]);
        check("write_data", bus.write_data, e[15:0]);
      end
    end
    if (frame_done_strobe === 1'b1) act_done++;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b);
    model_bit(b);
    data_in = b;
    clock_in = 1'b0;
    tick($urandom_range(3, 5));
    clock_in = 1'b1;
    tick($urandom_range(3, 5));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic checkpoint(input string tag);
    tick(8);
    check({tag, "_words_written"}, words_written, m_ww);
    check({tag, "_header_error"}, header_error, m_herr);
    check({tag, "_overflow"}, overflow, m_ovf);
    check({tag, "_frame_done_count"}, act_done, m_done);
    check({tag, "_pending_writes"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    model_reset();
    m_done = 0;

    // Reset state
    tick(3);
    check("reset_strobe", bus.write_strobe, 0);
    check("reset_addr", bus.write_address, 0);
    check("reset_data", bus.write_data, 0);
    check("reset_words", words_written, 0);
    check("reset_flags", {frame_done_strobe, header_error, overflow}, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b1;
    tick(3);

    // Basic frame
    start_address = 16'h0100; max_words = 16'd8;
    send_zeros(32);
    strobe_cyc.delete();
    send_word(32'hE1FF0000);
    send_word(32'hFF00FF00);
    checkpoint("basic");
    check("basic_count", words_written, 4);
    check("basic_strobes", strobe_cyc.size(), 4);
    if (strobe_cyc.size() == 4) begin
      check("basic_pair0_gap", 32'(strobe_cyc[1] - strobe_cyc[0]), 1);
      check("basic_pair1_gap", 32'(strobe_cyc[3] - strobe_cyc[2]), 1);
    end
    check("basic_last_addr", bus.write_address, 16'h0103);

    // Header error
    start_address = 16'h2000; max_words = 16'd8;
    send_zeros(32);
    send_word(32'hA5A5A5A5);
    send_word(32'hE0000001);
    checkpoint("header");
    check("header_flag", header_error, 1);
    check("header_words", words_written, 2);

    // Overflow and address wrap
    start_address = 16'hFFFF; max_words = 16'd3;
    send_zeros(32);
    send_word(32'hE0011234);
    send_word(32'hE5556789);
    checkpoint("overflow");
    check("overflow_flag", overflow, 1);
    check("overflow_last_addr", bus.write_address, 16'h0001);

    // Resync on a partial frame
    start_address = 16'h0040; max_words = 16'd8;
    send_zeros(32);
    send_word(32'hE0AA0055);
    checkpoint("resync_a");
    n = act_done;
    w = 32'h43210000;
    for (int i = 31; i >= 16; i--) send_bit(w[i]);
    send_zeros(32);
    checkpoint("resync_b");
    check("resync_done_once", act_done - n, 1);
    send_word(32'hE7770888);
    checkpoint("resync_c");
    check("resync_addr", bus.write_address, 16'h0041);

    // Reset mid-SHIFT
    send_zeros(32);
    w = 32'hE1230000;
    for (int i = 31; i >= 16; i--) send_bit(w[i]);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("areset_strobe", bus.write_strobe, 0);
    check("areset_addr", bus.write_address, 0);
    check("areset_data", bus.write_data, 0);
    check("areset_words", words_written, 0);
    check("areset_flags", {frame_done_strobe, header_error, overflow}, 0);
    check("areset_state", dbg_state, 0);
    clock_in = 1'b0; data_in = 1'b0;
    model_reset();
    tick(3);
    rst = 1'b1;
    tick(2);
    send_word(32'hE1112222);
    checkpoint("post_reset_ignored");
    start_address = 16'h0500; max_words = 16'd4;
    send_zeros(32);
    send_word(32'hE3334444);
    checkpoint("post_reset_frame");

    // Randomized streams
    for (int r = 0; r < 8; r++) begin
      start_address = AW'($urandom);
      max_words = AW'($urandom_range(0, 6));
      send_zeros(32 + $urandom_range(0, 4));
      n = $urandom_range(1, 3);
      for (int f = 0; f < n; f++) begin
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[31:29] = 3'b111;
        send_word(w);
      end
      checkpoint("random");
    end

`ifdef APA102_IN_TIMEOUT_EN
    // Idle timeout closes the frame
    start_address = 16'h0300; max_words = 16'd8;
    send_zeros(32);
    send_word(32'hE00000FF);
    n = act_done;
    tick(TIMEOUT_CYCLES + 50);
    if (m_armed) begin
      if (m_ww != 0) m_done++;
      m_armed = 0; m_hunt = 0; m_nbits = 0;
    end
    checkpoint("timeout");
    check("timeout_done_once", act_done - n, 1);
    check("timeout_state", dbg_state, 0);
    check("timeout_words", words_written, 2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
